// File: rtl/aes_shift_pkg.sv
// Shared helpers for the Rijndael ShiftRows datapath: row offsets, byte
// addressing within a column-major state, and the legal block widths.
package aes_shift_pkg;

    localparam int NB_MIN = 4;
    localparam int NB_MAX = 8;

    // Rijndael shifts rows 2 and 3 one extra position for 256-bit blocks.
    function automatic int row_offset(input int nb, input int r);
        return (nb == 8 && r >= 2) ? r + 1 : r;
    endfunction

    function automatic int byte_index(input int c, input int r);
        return 4 * c + r;
    endfunction

    function automatic bit nb_is_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

endpackage

// File: rtl/shift_rows_stage.sv
// One elastic register slot: holds valid, direction, tag and state, and
// loads from upstream whenever the top grants it a load enable.
module shift_rows_stage #(
    parameter int W     = 128,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [W-1:0]     in_state,
    output logic             out_valid,
    output logic             out_inv,
    output logic [TAG_W-1:0] out_tag,
    output logic [W-1:0]     out_state
);

    logic             valid_q, valid_d;
    logic             inv_q, inv_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [W-1:0]     state_q, state_d;

    // Payload only moves with a real entry so bubbles leave it untouched.
    always_comb begin
        valid_d = valid_q;
        inv_d   = inv_q;
        tag_d   = tag_q;
        state_d = state_q;
        if (en) begin
            valid_d = in_valid;
            if (in_valid) begin
                inv_d   = in_inv;
                tag_d   = in_tag;
                state_d = in_state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inv_q   <= 1'b0;
            tag_q   <= '0;
            state_q <= '0;
        end else begin
            valid_q <= valid_d;
            inv_q   <= inv_d;
            tag_q   <= tag_d;
            state_q <= state_d;
        end
    end

    assign out_valid = valid_q;
    assign out_inv   = inv_q;
    assign out_tag   = tag_q;
    assign out_state = state_q;

endmodule

// File: rtl/shift_rows_pipe.sv
// Elastic ShiftRows / InvShiftRows for NB = 4, 6, 8: the byte permutation is
// pure wiring at the input, followed by STAGES register slots.
module shift_rows_pipe
    import aes_shift_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [32*NB-1:0]  in_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_inv,
    output logic [TAG_W-1:0]  out_tag,
    output logic [32*NB-1:0]  out_state
);

    localparam int W     = 32 * NB;
    localparam bit NB_OK = nb_is_legal(NB);

    if (!NB_OK) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1..4");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shift_rows_pipe: TAG_W must be at least 1");
    end

    logic [W-1:0] st_fwd, st_inv, st_xf;

    // Column 0 row 0 sits at the MSBs, so byte k lives at W-8-8k.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFF = row_offset(NB, r);
            localparam int DST = W - 8 - 8 * byte_index(c, r);
            localparam int SF  = W - 8 - 8 * byte_index((c + OFF) % NB, r);
            localparam int SI  = W - 8 - 8 * byte_index((c - OFF + NB) % NB, r);
            assign st_fwd[DST +: 8] = in_state[SF +: 8];
            assign st_inv[DST +: 8] = in_state[SI +: 8];
        end
    end

    assign st_xf = in_inv ? st_inv : st_fwd;

    logic [STAGES:0]            vld_pipe, inv_pipe;
    logic [STAGES:0][TAG_W-1:0] tag_pipe;
    logic [STAGES:0][W-1:0]     st_pipe;
    logic [STAGES:1]            ld;

    assign vld_pipe[0] = in_valid;
    assign inv_pipe[0] = in_inv;
    assign tag_pipe[0] = in_tag;
    assign st_pipe[0]  = st_xf;

    for (genvar i = 1; i <= STAGES; i++) begin : g_stage
        // Slot i can move if any slot from i to the tail is empty or the tail drains;
        // written flat so ready never chains through a combinational loop.
        assign ld[i] = out_ready || !(&vld_pipe[STAGES:i]);

        shift_rows_stage #(.W(W), .TAG_W(TAG_W)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (ld[i]),
            .in_valid  (vld_pipe[i-1]),
            .in_inv    (inv_pipe[i-1]),
            .in_tag    (tag_pipe[i-1]),
            .in_state  (st_pipe[i-1]),
            .out_valid (vld_pipe[i]),
            .out_inv   (inv_pipe[i]),
            .out_tag   (tag_pipe[i]),
            .out_state (st_pipe[i])
        );
    end

    assign in_ready  = ld[1];
    assign out_valid = vld_pipe[STAGES];
    assign out_inv   = inv_pipe[STAGES];
    assign out_tag   = tag_pipe[STAGES];
    assign out_state = st_pipe[STAGES];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: directed FIPS vectors, NB=8 latency, forward/inverse
// round trips for every NB, randomized stalls and mid-stream reset.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int errors = 0;
    int checks = 0;

    // NB=4, STAGES=1
    logic a_v, a_rdy, a_inv, a_ordy, a_ov, a_oinv;
    logic [3:0] a_tag, a_otag;
    logic [127:0] a_st, a_ost;
    // NB=8, STAGES=2
    logic b_v, b_rdy, b_inv, b_ordy, b_ov, b_oinv;
    logic [3:0] b_tag, b_otag;
    logic [255:0] b_st, b_ost;
    // NB=4, STAGES=3
    logic c_v, c_rdy, c_inv, c_ordy, c_ov, c_oinv;
    logic [7:0] c_tag, c_otag;
    logic [127:0] c_st, c_ost;
    // round-trip chains, shared stimulus
    logic rt_v;
    logic [7:0] rt_t;
    logic [255:0] rt_d;
    logic rr4, rr6, rr8;
    logic m4_v, m4_r, m4_i, o4_v, o4_i;
    logic m6_v, m6_r, m6_i, o6_v, o6_i;
    logic m8_v, m8_r, m8_i, o8_v, o8_i;
    logic [7:0] m4_t, o4_t, m6_t, o6_t, m8_t, o8_t;
    logic [127:0] m4_s, o4_s;
    logic [191:0] m6_s, o6_s;
    logic [255:0] m8_s, o8_s;

    shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_v), .in_ready(a_rdy), .in_inv(a_inv), .in_tag(a_tag),
        .in_state(a_st), .out_valid(a_ov), .out_ready(a_ordy), .out_inv(a_oinv), .out_tag(a_otag),
        .out_state(a_ost));
    shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_v), .in_ready(b_rdy), .in_inv(b_inv), .in_tag(b_tag),
        .in_state(b_st), .out_valid(b_ov), .out_ready(b_ordy), .out_inv(b_oinv), .out_tag(b_otag),
        .out_state(b_ost));
    shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(8)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_v), .in_ready(c_rdy), .in_inv(c_inv), .in_tag(c_tag),
        .in_state(c_st), .out_valid(c_ov), .out_ready(c_ordy), .out_inv(c_oinv), .out_tag(c_otag),
        .out_state(c_ost));

    shift_rows_pipe #(.NB(4), .STAGES(2), .TAG_W(8)) u_f4 (
        .clk(clk), .rst(rst), .in_valid(rt_v), .in_ready(rr4), .in_inv(1'b0), .in_tag(rt_t),
        .in_state(rt_d[127:0]), .out_valid(m4_v), .out_ready(m4_r), .out_inv(m4_i), .out_tag(m4_t),
        .out_state(m4_s));
    shift_rows_pipe #(.NB(4), .STAGES(2), .TAG_W(8)) u_i4 (
        .clk(clk), .rst(rst), .in_valid(m4_v), .in_ready(m4_r), .in_inv(1'b1), .in_tag(m4_t),
        .in_state(m4_s), .out_valid(o4_v), .out_ready(1'b1), .out_inv(o4_i), .out_tag(o4_t),
        .out_state(o4_s));
    shift_rows_pipe #(.NB(6), .STAGES(2), .TAG_W(8)) u_f6 (
        .clk(clk), .rst(rst), .in_valid(rt_v), .in_ready(rr6), .in_inv(1'b0), .in_tag(rt_t),
        .in_state(rt_d[191:0]), .out_valid(m6_v), .out_ready(m6_r), .out_inv(m6_i), .out_tag(m6_t),
        .out_state(m6_s));
    shift_rows_pipe #(.NB(6), .STAGES(2), .TAG_W(8)) u_i6 (
        .clk(clk), .rst(rst), .in_valid(m6_v), .in_ready(m6_r), .in_inv(1'b1), .in_tag(m6_t),
        .in_state(m6_s), .out_valid(o6_v), .out_ready(1'b1), .out_inv(o6_i), .out_tag(o6_t),
        .out_state(o6_s));
    shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(8)) u_f8 (
        .clk(clk), .rst(rst), .in_valid(rt_v), .in_ready(rr8), .in_inv(1'b0), .in_tag(rt_t),
        .in_state(rt_d), .out_valid(m8_v), .out_ready(m8_r), .out_inv(m8_i), .out_tag(m8_t),
        .out_state(m8_s));
    shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(8)) u_i8 (
        .clk(clk), .rst(rst), .in_valid(m8_v), .in_ready(m8_r), .in_inv(1'b1), .in_tag(m8_t),
        .in_state(m8_s), .out_valid(o8_v), .out_ready(1'b1), .out_inv(o8_i), .out_tag(o8_t),
        .out_state(o8_s));

    // Reference permutation straight from the row-rotation rule; state right-aligned.
    function automatic logic [255:0] ref_shift(input int nb, input logic inv, input logic [255:0] s);
        logic [7:0] b [32];
        logic [255:0] o;
        int off [4];
        int src;
        o = '0;
        if (nb == 8) off = '{0, 1, 3, 4};
        else         off = '{0, 1, 2, 3};
        for (int k = 0; k < 4 * nb; k++) b[k] = s[8 * (4 * nb - 1 - k) +: 8];
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
                o[8 * (4 * nb - 1 - (4 * c + r)) +: 8] = b[4 * src + r];
            end
        end
        return o;
    endfunction

    task automatic test_reset();
        checks++;
        if (a_ov !== 1'b0 || a_ost !== 128'h0 || a_oinv !== 1'b0 || a_otag !== 4'h0)
            begin errors++; $display("FAIL reset_outputs: valid=%b inv=%b tag=%h state=%h required all zero", a_ov, a_oinv, a_otag, a_ost); end
        checks++;
        if (a_rdy !== 1'b1 || c_rdy !== 1'b1)
            begin errors++; $display("FAIL reset_in_ready: a=%b c=%b required 1", a_rdy, c_rdy); end
        checks++;
        if (b_ov !== 1'b0 || c_ov !== 1'b0)
            begin errors++; $display("FAIL reset_valid: b=%b c=%b required 0", b_ov, c_ov); end
    endtask

    task automatic test_fips();
        a_st = 128'h000102030405060708090A0B0C0D0E0F;
        a_v = 1'b1; a_inv = 1'b0; a_tag = 4'h5; a_ordy = 1'b1;
        @(negedge clk); a_inv = 1'b1; a_tag = 4'h6; #1;
        checks++;
        if (a_ov !== 1'b1 || a_ost !== 128'h00050A0F04090E03080D02070C01060B)
            begin errors++; $display("FAIL fips_forward: valid=%b state=%h required 1 00050a0f04090e03080d02070c01060b", a_ov, a_ost); end
        checks++;
        if (a_otag !== 4'h5 || a_oinv !== 1'b0)
            begin errors++; $display("FAIL fips_forward_side: tag=%h inv=%b required 5 0", a_otag, a_oinv); end
        @(negedge clk); a_v = 1'b0; #1;
        checks++;
        if (a_ov !== 1'b1 || a_ost !== 128'h000D0A0704010E0B0805020F0C090603)
            begin errors++; $display("FAIL fips_inverse: valid=%b state=%h required 1 000d0a0704010e0b0805020f0c090603", a_ov, a_ost); end
        checks++;
        if (a_otag !== 4'h6 || a_oinv !== 1'b1)
            begin errors++; $display("FAIL fips_inverse_side: tag=%h inv=%b required 6 1", a_otag, a_oinv); end
        @(negedge clk); #1;
        checks++;
        if (a_ov !== 1'b0) begin errors++; $display("FAIL fips_drain: valid=%b required 0", a_ov); end
    endtask

    task automatic test_nb8_latency();
        logic [255:0] e;
        for (int k = 0; k < 32; k++) b_st[8 * (31 - k) +: 8] = 8'(k);
        b_v = 1'b1; b_inv = 1'b0; b_tag = 4'hA; b_ordy = 1'b1;
        e = ref_shift(8, 1'b0, b_st);
        @(negedge clk); b_v = 1'b0; #1;
        checks++;
        if (b_ov !== 1'b0) begin errors++; $display("FAIL nb8_early: valid=%b required 0 after 1 cycle", b_ov); end
        @(negedge clk); #1;
        checks++;
        if (b_ov !== 1'b1) begin errors++; $display("FAIL nb8_latency: valid=%b required 1 after 2 cycles", b_ov); end
        checks++;
        if (b_ost[255:224] !== 32'h00050E13 || b_ost[31:0] !== 32'h1C010A0F)
            begin errors++; $display("FAIL nb8_columns: col0=%h col7=%h required 00050e13 1c010a0f", b_ost[255:224], b_ost[31:0]); end
        checks++;
        if (b_ost !== e || b_otag !== 4'hA)
            begin errors++; $display("FAIL nb8_state: state=%h tag=%h required %h a", b_ost, b_otag, e); end
        @(negedge clk); #1;
        checks++;
        if (b_ov !== 1'b0) begin errors++; $display("FAIL nb8_drain: valid=%b required 0", b_ov); end
    endtask

    task automatic test_round_trip();
        logic [255:0] mq[$], dq[$];
        logic [7:0] tq[$];
        logic [255:0] d, e4, e6, e8;
        logic [7:0] t;
        int sent = 0, got = 0, cyc = 0;
        while (got < 1000 && cyc < 6000) begin
            @(negedge clk); cyc++;
            rt_v = (sent < 1000) && ($urandom_range(0, 3) != 0);
            rt_t = 8'($urandom);
            rt_d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            if (m4_v === 1'b1 || m6_v === 1'b1 || m8_v === 1'b1) begin
                checks++;
                if (mq.size() == 0 || m4_v !== 1'b1 || m6_v !== 1'b1 || m8_v !== 1'b1) begin
                    errors++; $display("FAIL rt_mid_valid: v4=%b v6=%b v8=%b pending=%0d required all 1 with pending", m4_v, m6_v, m8_v, mq.size());
                end else begin
                    d = mq.pop_front();
                    e4 = ref_shift(4, 1'b0, {128'h0, d[127:0]});
                    e6 = ref_shift(6, 1'b0, {64'h0, d[191:0]});
                    e8 = ref_shift(8, 1'b0, d);
                    if (m4_s !== e4[127:0] || m6_s !== e6[191:0] || m8_s !== e8) begin
                        errors++; $display("FAIL rt_forward: ok4=%b ok6=%b state8=%h required %h", m4_s === e4[127:0], m6_s === e6[191:0], m8_s, e8);
                    end
                end
            end
            if (o4_v === 1'b1 || o6_v === 1'b1 || o8_v === 1'b1) begin
                checks++;
                if (dq.size() == 0 || o4_v !== 1'b1 || o6_v !== 1'b1 || o8_v !== 1'b1) begin
                    errors++; $display("FAIL rt_out_valid: v4=%b v6=%b v8=%b pending=%0d required all 1 with pending", o4_v, o6_v, o8_v, dq.size());
                end else begin
                    d = dq.pop_front(); t = tq.pop_front(); got++;
                    if (o4_s !== d[127:0] || o6_s !== d[191:0] || o8_s !== d || o4_t !== t || o6_t !== t || o8_t !== t
                        || {o4_i, o6_i, o8_i} !== 3'b111) begin
                        errors++; $display("FAIL rt_identity: tags=%h/%h/%h state8=%h required tag %h state %h", o4_t, o6_t, o8_t, o8_s, t, d);
                    end
                end
            end
            if (rt_v) begin
                checks++;
                if ({rr4, rr6, rr8} !== 3'b111) begin
                    errors++; $display("FAIL rt_in_ready: ready=%b required 111", {rr4, rr6, rr8});
                end else begin
                    mq.push_back(rt_d); dq.push_back(rt_d); tq.push_back(rt_t); sent++;
                end
            end
        end
        rt_v = 1'b0;
        checks++;
        if (got != 1000) begin errors++; $display("FAIL rt_count: received=%0d required 1000", got); end
    endtask

    task automatic test_stall();
        logic [7:0] tq[$];
        logic iq[$];
        logic [127:0] sq[$];
        logic [255:0] e;
        logic [127:0] h_st;
        logic [7:0] h_tag;
        logic h_inv, exp_rdy;
        bit held = 1'b0;
        int sent = 0, got = 0, cyc = 0;
        while (got < 200 && cyc < 4000) begin
            @(negedge clk); cyc++;
            c_v = (sent < 200) && ($urandom_range(0, 1) == 1);
            c_tag = 8'(sent);
            c_inv = 1'($urandom);
            c_st = {$urandom, $urandom, $urandom, $urandom};
            c_ordy = 1'($urandom);
            #1;
            if (held) begin
                checks++;
                if (c_ov !== 1'b1 || c_ost !== h_st || c_otag !== h_tag || c_oinv !== h_inv) begin
                    errors++; $display("FAIL stall_hold: valid=%b tag=%h inv=%b state=%h required 1 %h %b %h", c_ov, c_otag, c_oinv, c_ost, h_tag, h_inv, h_st);
                end
            end
            exp_rdy = !(tq.size() == 3 && !c_ordy);
            checks++;
            if (c_rdy !== exp_rdy) begin
                errors++; $display("FAIL stall_in_ready: in_ready=%b required %b held=%0d out_ready=%b", c_rdy, exp_rdy, tq.size(), c_ordy);
            end
            if (c_ov === 1'b1 && c_ordy) begin
                checks++;
                if (tq.size() == 0) begin
                    errors++; $display("FAIL stall_spurious: tag=%h arrived with nothing outstanding", c_otag);
                end else begin
                    if (c_otag !== tq[0] || c_oinv !== iq[0] || c_ost !== sq[0]) begin
                        errors++; $display("FAIL stall_order: tag=%h inv=%b state=%h required %h %b %h", c_otag, c_oinv, c_ost, tq[0], iq[0], sq[0]);
                    end
                    void'(tq.pop_front()); void'(iq.pop_front()); void'(sq.pop_front()); got++;
                end
            end
            if (c_v && c_rdy === 1'b1) begin
                e = ref_shift(4, c_inv, {128'h0, c_st});
                tq.push_back(c_tag); iq.push_back(c_inv); sq.push_back(e[127:0]); sent++;
            end
            held = (c_ov === 1'b1) && !c_ordy;
            h_st = c_ost; h_tag = c_otag; h_inv = c_oinv;
        end
        c_v = 1'b0; c_ordy = 1'b1;
        checks++;
        if (got != 200) begin errors++; $display("FAIL stall_count: received=%0d required 200", got); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        c_ordy = 1'b0; c_v = 1'b1; c_inv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c_tag = 8'(8'hA0 + i);
            c_st = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
            @(negedge clk);
        end
        c_v = 1'b0; #1;
        checks++;
        if (c_rdy !== 1'b0 || c_ov !== 1'b1)
            begin errors++; $display("FAIL midrst_full: in_ready=%b valid=%b required 0 1", c_rdy, c_ov); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (c_ov !== 1'b0 || c_ost !== 128'h0 || c_otag !== 8'h0 || c_oinv !== 1'b0)
            begin errors++; $display("FAIL midrst_clear: valid=%b tag=%h state=%h required 0 00 0", c_ov, c_otag, c_ost); end
        checks++;
        if (c_rdy !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: in_ready=%b required 1", c_rdy); end
        c_ordy = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
            checks++;
            if (c_ov !== 1'b0) begin errors++; $display("FAIL midrst_stale: valid=%b tag=%h required no output", c_ov, c_otag); end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_v = 0; a_inv = 0; a_tag = '0; a_st = '0; a_ordy = 1;
        b_v = 0; b_inv = 0; b_tag = '0; b_st = '0; b_ordy = 1;
        c_v = 0; c_inv = 0; c_tag = '0; c_st = '0; c_ordy = 1;
        rt_v = 0; rt_t = '0; rt_d = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        test_reset();
        test_fips();
        test_nb8_latency();
        test_round_trip();
        test_stall();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
